// File: rtl/bus_arb_pkg.sv
// Shared constants and helpers for the bus arbiter and its next-owner picker.
// Latency: none (package only).
// Backpressure: not applicable.
package bus_arb_pkg;

  // Arbitration policy encodings for the ARB_MODE parameter
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Tenure counter width; TENURE_MAX is limited to what this counter can reach
  localparam int TENURE_W  = 8;

  // Ceiling log2 of n, bounded loop so it elaborates as a constant function
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Width of the owner index for n masters (never narrower than one bit)
  function automatic int owner_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Next-owner search: fixed-priority or cyclic search over an active-high request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; o_found low means no eligible requester exists.
module arb_pick
  import bus_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [OW-1:0] i_owner,
  input  logic          i_exclude,
  input  logic          i_rr,
  output logic [OW-1:0] o_idx,
  output logic          o_found
);

  // Scan candidates from least to most preferred so the preferred one is written last
  always_comb begin
    int j;
    o_idx   = '0;
    o_found = 1'b0;
    j       = 0;
    if (!i_rr) begin
      // Fixed priority: lowest index wins
      for (int i = N - 1; i >= 0; i--) begin
        if (i_req[i] && !(i_exclude && (i == int'(i_owner)))) begin
          o_idx   = OW'(i);
          o_found = 1'b1;
        end
      end
    end else begin
      // Round robin: owner+1 is most preferred, the owner itself least
      for (int k = N; k >= 1; k--) begin
        j = (int'(i_owner) + k) % N;
        if (i_req[j] && !(i_exclude && (j == int'(i_owner)))) begin
          o_idx   = OW'(j);
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Parked bus arbiter with active-low request/grant, fixed or round-robin policy, tenure limit.
// Latency: one cycle from a sampled request to the registered grant.
// Backpressure: none; waiting masters keep req_ low until grnt_ is seen low.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int MASTER_CH  = 4,
  parameter  int ARB_MODE   = 1,
  parameter  int TENURE_MAX = 16,
  localparam int OWNER_W    = owner_w(MASTER_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MASTER_CH-1:0] req_,
  output logic [MASTER_CH-1:0] grnt_,
  output logic [OWNER_W-1:0]   owner,
  output logic                 arb_switch
);

  localparam logic [MASTER_CH-1:0] ONE_HOT0 = MASTER_CH'(1);
  localparam bit                   TEN_EN   = (TENURE_MAX != 0);
  localparam logic [TENURE_W-1:0]  TEN_LAST = (TENURE_MAX == 0) ? '0 : TENURE_W'(TENURE_MAX - 1);
  localparam logic [TENURE_W-1:0]  TEN_SAT  = '1;

  logic [OWNER_W-1:0]   r_owner;
  logic [MASTER_CH-1:0] r_grnt_n;
  logic                 r_switch;
  logic [TENURE_W-1:0]  r_tenure;

  logic [MASTER_CH-1:0] w_req;
  logic [MASTER_CH-1:0] w_owner_mask;
  logic                 w_owner_req;
  logic                 w_others;
  logic                 w_tenure_hit;
  logic                 w_rearb;
  logic [OWNER_W-1:0]   w_pick;
  logic                 w_found;
  logic                 w_change;

  // Work internally with active-high requests
  assign w_req        = ~req_;
  assign w_owner_mask = ONE_HOT0 << r_owner;
  assign w_owner_req  = |(w_req & w_owner_mask);
  assign w_others     = |(w_req & ~w_owner_mask);

  // Tenure expiry only matters while somebody else is waiting
  assign w_tenure_hit = TEN_EN && (r_tenure == TEN_LAST) && w_others;

  // Rearbitrate on release or on tenure expiry; expiry excludes the current owner
  assign w_rearb      = !w_owner_req || w_tenure_hit;

  arb_pick #(
    .N  (MASTER_CH),
    .OW (OWNER_W)
  ) u_pick (
    .i_req     (w_req),
    .i_owner   (r_owner),
    .i_exclude (w_tenure_hit),
    .i_rr      (ARB_MODE == ARB_RR),
    .o_idx     (w_pick),
    .o_found   (w_found)
  );

  // A successful search never returns the owner: it either released or was excluded
  assign w_change = w_rearb && w_found;

  // Owner, grant vector and switch pulse; grant stays parked when nobody else asks
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner  <= '0;
      r_grnt_n <= ~ONE_HOT0;
      r_switch <= 1'b0;
    end else begin
      r_switch <= w_change;
      if (w_change) begin
        r_owner  <= w_pick;
        r_grnt_n <= ~(ONE_HOT0 << w_pick);
      end
    end
  end

  // Tenure counter: counts contended cycles of the holding owner, clears otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tenure <= '0;
    end else if (w_change || !w_others) begin
      r_tenure <= '0;
    end else if (w_owner_req && (r_tenure != TEN_SAT)) begin
      r_tenure <= r_tenure + 1'b1;
    end
  end

  assign grnt_      = r_grnt_n;
  assign owner      = r_owner;
  assign arb_switch = r_switch;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [3:0] req_rr = 4'hF, req_f4 = 4'hF, req_f0 = 4'hF;
  logic [7:0] req_8 = 8'hFF;
  logic [3:0] grnt_rr, grnt_f4, grnt_f0;
  logic [7:0] grnt_8;
  logic [1:0] own_rr, own_f4, own_f0;
  logic [2:0] own_8;
  logic       sw_rr, sw_f4, sw_f0, sw_8;

  bus_arbiter #(.MASTER_CH(4), .ARB_MODE(1), .TENURE_MAX(16)) u_rr4 (
    .clk(clk), .reset(reset), .req_(req_rr), .grnt_(grnt_rr), .owner(own_rr), .arb_switch(sw_rr));
  bus_arbiter #(.MASTER_CH(4), .ARB_MODE(0), .TENURE_MAX(4)) u_fx4 (
    .clk(clk), .reset(reset), .req_(req_f4), .grnt_(grnt_f4), .owner(own_f4), .arb_switch(sw_f4));
  bus_arbiter #(.MASTER_CH(4), .ARB_MODE(0), .TENURE_MAX(0)) u_fx0 (
    .clk(clk), .reset(reset), .req_(req_f0), .grnt_(grnt_f0), .owner(own_f0), .arb_switch(sw_f0));
  bus_arbiter #(.MASTER_CH(8), .ARB_MODE(1), .TENURE_MAX(16)) u_rr8 (
    .clk(clk), .reset(reset), .req_(req_8), .grnt_(grnt_8), .owner(own_8), .arb_switch(sw_8));

  int checks = 0;
  int failures = 0;

  int    m_owner[4] = '{0, 0, 0, 0};
  int    m_ten[4]   = '{0, 0, 0, 0};
  int    m_n[4]     = '{4, 4, 4, 8};
  int    m_mode[4]  = '{1, 0, 0, 1};
  int    m_tmax[4]  = '{16, 4, 0, 16};
  string m_name[4]  = '{"rr4", "fx4", "fx0", "rr8"};

  typedef struct {
    int         d;
    logic [7:0] own;
    logic [7:0] gnt;
    logic       sw;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one arbiter; pushes the expected post-edge outputs
  task automatic model_push(input int d, input logic [7:0] q, input logic rst);
    logic [7:0] act;
    logic [7:0] mask;
    int  o, pick;
    bit  found, own_req, others, forced;
    exp_t e;
    act = ~q;
    for (int i = m_n[d]; i < 8; i++) act[i] = 1'b0;
    mask  = (m_n[d] == 8) ? 8'hFF : 8'h0F;
    o     = m_owner[d];
    found = 1'b0;
    if (!rst) begin
      m_owner[d] = 0;
      m_ten[d]   = 0;
    end else begin
      own_req = act[o];
      others  = 1'b0;
      for (int i = 0; i < m_n[d]; i++) if (i != o && act[i]) others = 1'b1;
      forced = (m_tmax[d] != 0) && (m_ten[d] == m_tmax[d] - 1) && others;
      pick = o;
      if (!own_req || forced) begin
        for (int k = 0; k < m_n[d]; k++) begin
          int i;
          i = (m_mode[d] == 0) ? k : (o + 1 + k) % m_n[d];
          if (!found && act[i] && !(forced && i == o)) begin
            found = 1'b1;
            pick  = i;
          end
        end
      end
      if (found) begin
        m_owner[d] = pick;
        m_ten[d]   = 0;
      end else if (!others) begin
        m_ten[d] = 0;
      end else if (own_req && m_ten[d] < 255) begin
        m_ten[d]++;
      end
    end
    e.d   = d;
    e.own = 8'(m_owner[d]);
    e.gnt = ~(8'd1 << m_owner[d]) & mask;
    e.sw  = found;
    sbq.push_back(e);
  endtask

  // One clock: drive at negedge, predict, sample #1 after posedge, drain scoreboard
  task automatic cyc(input logic rst, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [7:0] e8);
    logic [7:0] o_own[4];
    logic [7:0] o_gnt[4];
    logic       o_sw[4];
    exp_t x;
    @(negedge clk);
    reset = rst; req_rr = a; req_f4 = b; req_f0 = c; req_8 = e8;
    model_push(0, {4'hF, a}, rst);
    model_push(1, {4'hF, b}, rst);
    model_push(2, {4'hF, c}, rst);
    model_push(3, e8, rst);
    @(posedge clk);
    #1;
    o_own[0] = 8'(own_rr); o_gnt[0] = 8'(grnt_rr); o_sw[0] = sw_rr;
    o_own[1] = 8'(own_f4); o_gnt[1] = 8'(grnt_f4); o_sw[1] = sw_f4;
    o_own[2] = 8'(own_f0); o_gnt[2] = 8'(grnt_f0); o_sw[2] = sw_f0;
    o_own[3] = 8'(own_8);  o_gnt[3] = grnt_8;      o_sw[3] = sw_8;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk({m_name[x.d], "_owner"}, o_own[x.d], x.own);
      chk({m_name[x.d], "_grnt"},  o_gnt[x.d], x.gnt);
      chk({m_name[x.d], "_switch"}, 8'(o_sw[x.d]), 8'(x.sw));
    end
    checks++;
    assert ($onehot(~grnt_8)) else begin
      failures++;
      $error("FAIL rr8_onecold observed=%0h expected=one low bit", grnt_8);
    end
    checks++;
    assert ($onehot(~grnt_rr)) else begin
      failures++;
      $error("FAIL rr4_onecold observed=%0h expected=one low bit", grnt_rr);
    end
  endtask

  initial begin
    logic [3:0] b, c;

    // Reset state
    cyc(1'b0, 4'hF, 4'hF, 4'hF, 8'hFF);
    cyc(1'b0, 4'hF, 4'hF, 4'hF, 8'hFF);
    chk("rst_owner", 8'(own_rr), 8'd0);
    chk("rst_grnt4", 8'(grnt_rr), 8'h0E);
    chk("rst_switch", 8'(sw_rr), 8'd0);
    chk("rst_grnt8", grnt_8, 8'hFE);

    // rr4: 1 and 3 alternate on tenure; rr8: full rotation; fx4: forced rotation; fx0: no limit
    for (int cy = 0; cy < 130; cy++) begin
      b = (cy == 0) ? 4'b0111 : 4'b0001;
      c = (cy == 0) ? 4'b1011 : (cy < 11) ? 4'b1010 : (cy < 14) ? 4'b1110 : 4'b1111;
      cyc(1'b1, 4'b0101, b, c, 8'h00);
      if (cy == 0)  chk("rr4_first_owner", 8'(own_rr), 8'd1);
      if (cy == 15) chk("rr4_hold_owner", 8'(own_rr), 8'd1);
      if (cy == 16) chk("rr4_tenure_owner", 8'(own_rr), 8'd3);
      if (cy == 16) chk("rr4_tenure_switch", 8'(sw_rr), 8'd1);
      if (cy == 17) chk("rr4_switch_drop", 8'(sw_rr), 8'd0);
      if (cy == 32) chk("rr4_back_owner", 8'(own_rr), 8'd1);
      if (cy == 48) chk("rr4_again_owner", 8'(own_rr), 8'd3);
      if (cy == 3)  chk("fx4_hold_owner", 8'(own_f4), 8'd3);
      if (cy == 4)  chk("fx4_forced_owner", 8'(own_f4), 8'd1);
      if (cy == 4)  chk("fx4_forced_switch", 8'(sw_f4), 8'd1);
      if (cy == 7)  chk("fx4_clear_hold", 8'(own_f4), 8'd1);
      if (cy == 8)  chk("fx4_next_forced", 8'(own_f4), 8'd2);
      if (cy == 10) chk("fx0_unlimited", 8'(own_f0), 8'd2);
      if (cy == 11) chk("fx0_release_owner", 8'(own_f0), 8'd0);
      if (cy == 11) chk("fx0_release_switch", 8'(sw_f0), 8'd1);
      if (cy == 20) chk("fx0_parked", 8'(own_f0), 8'd0);
      if ((cy + 1) % 16 == 0) chk("rr8_rotation", 8'(own_8), 8'((cy + 1) / 16 % 8));
    end

    // rr4: owner 2 takes the bus, releases, everyone idle; one glitch between edges
    cyc(1'b1, 4'b1011, 4'hF, 4'hF, 8'hFF);
    chk("park_take_owner", 8'(own_rr), 8'd2);
    cyc(1'b1, 4'hF, 4'hF, 4'hF, 8'hFF);
    req_rr = 4'b0000;
    #2;
    req_rr = 4'b1111;
    cyc(1'b1, 4'hF, 4'hF, 4'hF, 8'hFF);
    cyc(1'b1, 4'hF, 4'hF, 4'hF, 8'hFF);
    chk("park_owner", 8'(own_rr), 8'd2);
    chk("park_grnt", 8'(grnt_rr), 8'h0B);
    chk("park_switch", 8'(sw_rr), 8'd0);

    // rr4: reset pulse in the middle of owner 3's contended tenure
    cyc(1'b1, 4'b0111, 4'b0000, 4'b0000, 8'h5A);
    chk("mid_owner3", 8'(own_rr), 8'd3);
    for (int k = 0; k < 5; k++) cyc(1'b1, 4'b0101, 4'b0000, 4'b0000, 8'h5A);
    cyc(1'b0, 4'b0101, 4'b0000, 4'b0000, 8'h5A);
    chk("mid_rst_owner", 8'(own_rr), 8'd0);
    chk("mid_rst_grnt", 8'(grnt_rr), 8'h0E);
    chk("mid_rst_switch", 8'(sw_rr), 8'd0);
    cyc(1'b1, 4'b0101, 4'b0000, 4'b0000, 8'h5A);
    chk("resume_owner", 8'(own_rr), 8'd1);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 4'b0101, 4'b0000, 4'b0000, 8'h5A);
      if (k == 14) chk("resume_full_tenure", 8'(own_rr), 8'd1);
      if (k == 15) chk("resume_tenure_end", 8'(own_rr), 8'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
